// File: rtl/mem_stage.sv
// MEM pipeline stage: synchronous data memory, load/store lane handling, two-cycle load FSM.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (traps misaligned accesses, adds misalign_out).

package mem_stage_pkg;
   localparam int LW_I  = 1;
   localparam int LH_I  = 2;
   localparam int LHU_I = 3;
   localparam int LB_I  = 4;
   localparam int LBU_I = 5;
   localparam int SW_I  = 6;
   localparam int SH_I  = 7;
   localparam int SB_I  = 8;
endpackage

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_WORDS = 1024,
   parameter int IOPBITS    = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [IOPBITS-1:0] in_op,
   input  logic [31:0]        in_pc,
   input  logic [31:0]        in_result,
   input  logic [31:0]        in_store_data,
   input  logic [4:0]         in_reg_dest,
   input  logic               in_wr_reg,
   output logic               stall_out,
   output logic               out_valid,
   output logic [31:0]        out_pc,
   output logic [31:0]        out_data,
   output logic [4:0]         out_reg_dest,
   output logic               out_wr_reg,
   output logic [4:0]         fwd_reg_dest,
   output logic               fwd_wr_reg
`ifdef MEM_MISALIGN_CHECK_EN
   ,
   output logic               misalign_out
`endif
);

   localparam int AW = $clog2(DMEM_WORDS);

   typedef enum logic {IDLE, LOAD_WAIT} state_e;

   state_e               state_q, state_d;
   logic                 out_valid_q, out_valid_d;
   logic [31:0]          out_pc_q, out_pc_d;
   logic [31:0]          out_data_q, out_data_d;
   logic [4:0]           out_reg_dest_q, out_reg_dest_d;
   logic                 out_wr_reg_q, out_wr_reg_d;
   logic [IOPBITS-1:0]   ld_op_q, ld_op_d;
   logic [31:0]          ld_pc_q, ld_pc_d;
   logic [1:0]           ld_off_q, ld_off_d;
   logic [4:0]           ld_dest_q, ld_dest_d;
   logic                 ld_wr_q, ld_wr_d;
`ifdef MEM_MISALIGN_CHECK_EN
   logic                 misalign_q, misalign_d;
`endif

   logic op_lw, op_lh, op_lhu, op_lb, op_lbu, op_sw, op_sh, op_sb;
   logic is_load, is_store, misalign, issue, mem_we;
   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wdata, ram_rdata, load_data;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   mem [DMEM_WORDS];

   assign op_lw  = (in_op == IOPBITS'(LW_I));
   assign op_lh  = (in_op == IOPBITS'(LH_I));
   assign op_lhu = (in_op == IOPBITS'(LHU_I));
   assign op_lb  = (in_op == IOPBITS'(LB_I));
   assign op_lbu = (in_op == IOPBITS'(LBU_I));
   assign op_sw  = (in_op == IOPBITS'(SW_I));
   assign op_sh  = (in_op == IOPBITS'(SH_I));
   assign op_sb  = (in_op == IOPBITS'(SB_I));

   assign is_load  = op_lw | op_lh | op_lhu | op_lb | op_lbu;
   assign is_store = op_sw | op_sh | op_sb;
   assign idx      = in_result[AW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = ((op_lw | op_sw) & (in_result[1:0] != 2'b00)) |
                     ((op_lh | op_lhu | op_sh) & in_result[0]);
`else
   assign misalign = 1'b0;
`endif

   // Only the IDLE cycle consumes in_*; during LOAD_WAIT the held AGEX contents are ignored.
   assign issue     = (state_q == IDLE) & in_valid & is_load & ~misalign;
   assign mem_we    = (state_q == IDLE) & in_valid & is_store & ~misalign & ~reset;
   assign stall_out = issue & ~reset;

   always_comb begin
      be    = 4'b0000;
      wdata = in_store_data;
      if (op_sb) begin
         be    = 4'b0001 << in_result[1:0];
         wdata = {4{in_store_data[7:0]}};
      end else if (op_sh) begin
         be    = in_result[1] ? 4'b1100 : 4'b0011;
         wdata = {2{in_store_data[15:0]}};
      end else if (op_sw) begin
         be    = 4'b1111;
      end
   end

   // NOTE: the data array has no reset branch; its contents survive reset and it stays mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (issue) ram_rdata <= mem[idx];
   end

   always_comb begin
      case (ld_off_q)
         2'd0:    ld_byte = ram_rdata[7:0];
         2'd1:    ld_byte = ram_rdata[15:8];
         2'd2:    ld_byte = ram_rdata[23:16];
         default: ld_byte = ram_rdata[31:24];
      endcase
      ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      if (ld_op_q == IOPBITS'(LB_I))       load_data = {{24{ld_byte[7]}}, ld_byte};
      else if (ld_op_q == IOPBITS'(LBU_I)) load_data = {24'h0, ld_byte};
      else if (ld_op_q == IOPBITS'(LH_I))  load_data = {{16{ld_half[15]}}, ld_half};
      else if (ld_op_q == IOPBITS'(LHU_I)) load_data = {16'h0, ld_half};
      else                                 load_data = ram_rdata;
   end

   // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      out_valid_d    = 1'b0;
      out_pc_d       = out_pc_q;
      out_data_d     = out_data_q;
      out_reg_dest_d = out_reg_dest_q;
      out_wr_reg_d   = 1'b0;
      ld_op_d        = ld_op_q;
      ld_pc_d        = ld_pc_q;
      ld_off_d       = ld_off_q;
      ld_dest_d      = ld_dest_q;
      ld_wr_d        = ld_wr_q;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d   = LOAD_WAIT;
               ld_op_d   = in_op;
               ld_pc_d   = in_pc;
               ld_off_d  = in_result[1:0];
               ld_dest_d = in_reg_dest;
               ld_wr_d   = in_wr_reg;
            end else if (in_valid) begin
               out_valid_d    = 1'b1;
               out_pc_d       = in_pc;
               out_data_d     = in_result;
               out_reg_dest_d = in_reg_dest;
               out_wr_reg_d   = in_wr_reg & ~is_store & ~misalign;
`ifdef MEM_MISALIGN_CHECK_EN
               misalign_d     = misalign;
`endif
            end
         end
         LOAD_WAIT: begin
            state_d        = IDLE;
            out_valid_d    = 1'b1;
            out_pc_d       = ld_pc_q;
            out_data_d     = load_data;
            out_reg_dest_d = ld_dest_q;
            out_wr_reg_d   = ld_wr_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         out_valid_q    <= 1'b0;
         out_pc_q       <= '0;
         out_data_q     <= '0;
         out_reg_dest_q <= '0;
         out_wr_reg_q   <= 1'b0;
         ld_op_q        <= '0;
         ld_pc_q        <= '0;
         ld_off_q       <= '0;
         ld_dest_q      <= '0;
         ld_wr_q        <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_q     <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         out_valid_q    <= out_valid_d;
         out_pc_q       <= out_pc_d;
         out_data_q     <= out_data_d;
         out_reg_dest_q <= out_reg_dest_d;
         out_wr_reg_q   <= out_wr_reg_d;
         ld_op_q        <= ld_op_d;
         ld_pc_q        <= ld_pc_d;
         ld_off_q       <= ld_off_d;
         ld_dest_q      <= ld_dest_d;
         ld_wr_q        <= ld_wr_d;
`ifdef MEM_MISALIGN_CHECK_EN
         misalign_q     <= misalign_d;
`endif
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = out_pc_q;
   assign out_data     = out_data_q;
   assign out_reg_dest = out_reg_dest_q;
   assign out_wr_reg   = out_wr_reg_q;
   // A pending load owns the hazard report until it lands in the MEM latch.
   assign fwd_wr_reg   = ~reset & ((state_q == LOAD_WAIT) | (out_wr_reg_q & out_valid_q));
   assign fwd_reg_dest = (state_q == LOAD_WAIT) ? ld_dest_q : out_reg_dest_q;
`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign_out = misalign_q;
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DMEM_WORDS, default 1024, number of 32-bit data memory words (power of two).
REQ-002 Parameter IOPBITS, default 6, width of the internal operation code (encodings LW_I, LH_I, LHU_I, LB_I, LBU_I, SW_I, SH_I, SB_I from define.vh).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  AGEX latch holds a live instruction.
REQ-006 in_op  input  IOPBITS  operation code from AGEX.
REQ-007 in_pc  input  32  instruction PC.
REQ-008 in_result  input  32  ALU result or effective address.
REQ-009 in_store_data  input  32  rs2 value for stores.
REQ-010 in_reg_dest  input  5  destination register index.
REQ-011 in_wr_reg  input  1  instruction writes a register.
REQ-012 stall_out  output  1  holds AGEX latch and everything upstream.
REQ-013 out_valid, out_pc[31:0], out_data[31:0], out_reg_dest[4:0], out_wr_reg  output  MEM latch fields to WB.
REQ-014 fwd_reg_dest[4:0], fwd_wr_reg  output  in-flight destination to DE for hazard check (out_* of current MEM latch plus pending load).

Function
REQ-015 Data memory SHALL be a synchronous-read array indexed by in_result[log2(DMEM_WORDS)+1:2]; address bits above the index wrap.
REQ-016 FSM states IDLE, LOAD_WAIT; reset state IDLE.
REQ-017 IDLE, non-memory op with in_valid: MEM latch captures in_result as out_data next edge; latency 1; stall_out=0.
REQ-018 IDLE, load with in_valid: issue RAM read, go LOAD_WAIT, stall_out=1 combinationally that cycle; out_valid=0 next edge (bubble).
REQ-019 LOAD_WAIT: extract/extend RAM data, capture into MEM latch with out_valid=1, return IDLE, stall_out=0; total load latency 2 cycles.
REQ-020 Extraction: LB/LBU select byte in_result[1:0], LH/LHU halfword in_result[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-021 Stores: write in the IDLE cycle with byte enables (SB one lane, SH lanes {1:0} or {3:2}, SW all); latency 1; out_wr_reg forced 0.
REQ-022 Read-after-write to same word on consecutive instructions SHALL return the new data.
REQ-023 in_valid=0 SHALL produce out_valid=0 and no memory write.
REQ-024 Load inputs SHALL be latched at issue; changes on in_* during LOAD_WAIT are ignored.
REQ-025 fwd_wr_reg SHALL be 1 during LOAD_WAIT with fwd_reg_dest = pending load destination; otherwise mirrors out_wr_reg&out_valid.

Reset
REQ-026 reset SHALL force IDLE, out_valid=0, out_wr_reg=0, out_pc/out_data/out_reg_dest=0, stall_out=0, fwd_wr_reg=0.
REQ-027 reset during LOAD_WAIT SHALL abandon the load; no MEM latch update.
REQ-028 Memory contents SHALL not be cleared by reset.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN: when defined, LW with in_result[1:0]!=0, LH/LHU/SH with in_result[0]=1, or SW misaligned SHALL suppress the write, set out_wr_reg=0, and assert extra output misalign_out=1 for that instruction's MEM cycle.
REQ-030 Without MEM_MISALIGN_CHECK_EN: no misalign_out port; low address bits ignored for word/half accesses (aligned down).

Verification
REQ-031 SW 0xDEADBEEF to 0x10, then LW from 0x10 -> out_data=0xDEADBEEF two cycles after load issue, stall_out high exactly one cycle.
REQ-032 SB 0x80 to 0x13, LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; other bytes of word unchanged.
REQ-033 ADD result 0x1234 dest x5 -> out_data=0x1234, out_reg_dest=5, out_wr_reg=1 next cycle, no stall.
REQ-034 Load issued, reset asserted in LOAD_WAIT -> out_valid=0, stall_out=0, FSM IDLE next cycle.
REQ-035 With MEM_MISALIGN_CHECK_EN, SW to 0x11 -> misalign_out=1, word at 0x10 unchanged on readback.
REQ-036 Back-to-back LW x1 then ADD -> fwd_wr_reg=1, fwd_reg_dest=1 during LOAD_WAIT; ADD held by stall_out, completes cycle after load.
